// File: rtl/divergence_roller_pkg.sv
// Shared types, display codes and the nibble-to-digit mapping for the divergence roller.
package divergence_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    SETTLE
  } state_t;

  localparam logic [3:0]  DIG_POINT    = 4'hE;
  localparam logic [3:0]  DIG_BLANK    = 4'hF;
  localparam logic [31:0] DEFAULT_POLY = 32'h0000_00AF;

  // 10..15 fold back onto 5..0 so every random nibble shows a decimal digit.
  function automatic logic [3:0] nibble_to_digit(input logic [3:0] n);
    return (n < 4'd10) ? n : ~n;
  endfunction

endpackage

// File: rtl/divergence_roller_if.sv
// Control/display bundle between the meter FSM (master) and the digit roller (slave).
interface divergence_roller_if #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned LFSR_W = 32
);

  logic [LFSR_W-1:0]   seed;
  logic                reseed;
  logic                start;
  logic [4*DIGITS-1:0] target;
  logic [4*DIGITS-1:0] digits;
  logic                busy;
  logic                done;

  modport master (
    output seed, reseed, start, target,
    input  digits, busy, done
  );

  modport slave (
    input  seed, reseed, start, target,
    output digits, busy, done
  );

endinterface

// File: rtl/divergence_roller_lfsr.sv
// Galois LFSR with load priority over step; a zero load value is replaced by 1.
module lfsr_galois
  import divergence_pkg::*;
#(
  parameter int unsigned W    = 32,
  parameter logic [W-1:0] POLY = W'(DEFAULT_POLY)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] state
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;
  logic [W-1:0] stepped;

  // POLY[0] is unused: bit 0 always takes the MSB directly.
  assign stepped = {state_q[W-2:0], state_q[W-1]} ^ ({POLY[W-1:1], 1'b0} & {W{state_q[W-1]}});

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (load_val == '0) ? W'(1) : load_val;
    end else if (step) begin
      state_d = stepped;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/divergence_roller.sv
// Nixie digit roller: scramble all digits, then lock to target MSB first, one per settle period.
// Optional DIVERGENCE_DP_EN pins digit DP_POS to the point code and skips it in the lock order.
module divergence_roller
  import divergence_pkg::*;
#(
  parameter int unsigned       DIGITS       = 8,
  parameter int unsigned       LFSR_W       = 32,
  parameter logic [LFSR_W-1:0] POLY         = LFSR_W'(DEFAULT_POLY),
  parameter int unsigned       TICK_DIV     = 10,
  parameter int unsigned       ROLL_TICKS   = 16,
  parameter int unsigned       SETTLE_TICKS = 4,
  parameter int unsigned       DP_POS       = 7
) (
  input  logic                clk,
  input  logic                rst,
  divergence_roller_if.slave  bus
);

  localparam int unsigned CW = (TICK_DIV > 1)     ? $clog2(TICK_DIV)     : 1;
  localparam int unsigned RW = (ROLL_TICKS > 1)   ? $clog2(ROLL_TICKS)   : 1;
  localparam int unsigned SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
  localparam int unsigned LW = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;

`ifdef DIVERGENCE_DP_EN
  localparam bit DP_ON = 1'b1;
`else
  localparam bit DP_ON = 1'b0;
`endif

  localparam int unsigned FIRST_LOCK = (DP_ON && DP_POS == DIGITS - 1) ? DIGITS - 2 : DIGITS - 1;
  localparam int unsigned LAST_LOCK  = (DP_ON && DP_POS == 0) ? 1 : 0;

  if (LFSR_W < 4 * DIGITS) begin : g_bad_width
    $error("divergence_roller: LFSR_W must be >= 4*DIGITS");
  end

  // ---------------------------------------------------------------- tick
  logic [CW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------- LFSR
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_load;

  // A cleared LFSR would stay stuck at zero, so the first tick after reset reloads the seed.
  assign lfsr_load = bus.reseed | (tick & ~|lfsr);

  lfsr_galois #(
    .W    (LFSR_W),
    .POLY (POLY)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .step     (tick),
    .load     (lfsr_load),
    .load_val (bus.seed),
    .state    (lfsr)
  );

  logic [4*DIGITS-1:0] rnd;

  always_comb begin
    rnd = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      rnd[4*i +: 4] = nibble_to_digit(lfsr[4*i +: 4]);
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t              state_q;
  logic [4*DIGITS-1:0] target_q;
  logic [4*DIGITS-1:0] digits_q;
  logic [RW-1:0]       roll_cnt_q;
  logic [SW-1:0]       settle_cnt_q;
  logic [LW-1:0]       lock_q;
  logic [LW-1:0]       lock_dec;
  logic                busy_q;
  logic                done_q;

  always_comb begin
    lock_dec = lock_q - 1'b1;
    if (DP_ON && lock_dec == LW'(DP_POS)) begin
      lock_dec = lock_q - LW'(2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      target_q     <= '0;
      digits_q     <= '0;
      roll_cnt_q   <= '0;
      settle_cnt_q <= '0;
      lock_q       <= LW'(DIGITS - 1);
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            target_q     <= bus.target;
            roll_cnt_q   <= '0;
            settle_cnt_q <= '0;
            lock_q       <= LW'(FIRST_LOCK);
            busy_q       <= 1'b1;
            state_q      <= ROLL;
          end
        end
        ROLL: begin
          if (tick) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
              if (!(DP_ON && i == DP_POS)) begin
                digits_q[4*i +: 4] <= rnd[4*i +: 4];
              end
            end
            if (roll_cnt_q == RW'(ROLL_TICKS - 1)) begin
              settle_cnt_q <= '0;
              state_q      <= SETTLE;
            end else begin
              roll_cnt_q <= roll_cnt_q + 1'b1;
            end
          end
        end
        SETTLE: begin
          if (tick) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
              if (!(DP_ON && i == DP_POS)) begin
                digits_q[4*i +: 4] <= (LW'(i) <= lock_q) ? rnd[4*i +: 4] : target_q[4*i +: 4];
              end
            end
            if (settle_cnt_q == SW'(SETTLE_TICKS - 1)) begin
              settle_cnt_q             <= '0;
              digits_q[4*lock_q +: 4] <= target_q[4*lock_q +: 4];
              if (lock_q == LW'(LAST_LOCK)) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                lock_q <= lock_dec;
              end
            end else begin
              settle_cnt_q <= settle_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef DIVERGENCE_DP_EN
      digits_q[4*DP_POS +: 4] <= DIG_POINT;
`endif
    end
  end

  assign bus.digits = digits_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_divergence_roller.sv
// Directed scoreboard bench for divergence_roller (TICK_DIV=2, ROLL_TICKS=4, SETTLE_TICKS=2).
module tb_divergence_roller;
  import divergence_pkg::*;

  localparam int unsigned TD = 2;
  localparam int unsigned RT = 4;
  localparam int unsigned ST = 2;
`ifdef DIVERGENCE_DP_EN
  localparam bit DP = 1'b1;
`else
  localparam bit DP = 1'b0;
`endif
  localparam int unsigned NLOCK    = DP ? 7 : 8;
  localparam int unsigned DONE_T   = RT + NLOCK * ST;
  localparam logic [31:0] IDLE_DIG = DP ? 32'hE000_0000 : 32'h0;
  localparam logic [31:0] POLY_REF = 32'h0000_00AF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  divergence_roller_if #(.DIGITS(8), .LFSR_W(32)) bus ();

  divergence_roller #(
    .DIGITS       (8),
    .LFSR_W       (32),
    .POLY         (32'h0000_00AF),
    .TICK_DIV     (TD),
    .ROLL_TICKS   (RT),
    .SETTLE_TICKS (ST),
    .DP_POS       (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int unsigned sb_q[$];
  logic [31:0] lfsr_q[$];
  logic [31:0] cur_dig;

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] r;
    r[0] = s[31];
    for (int k = 1; k < 32; k++) r[k] = s[k-1] ^ (POLY_REF[k] & s[31]);
    return r;
  endfunction

  function automatic logic [31:0] map_all(input logic [31:0] s);
    logic [31:0] r;
    logic [3:0]  n;
    for (int i = 0; i < 8; i++) begin
      n = s[4*i +: 4];
      r[4*i +: 4] = (n > 4'd9) ? 4'd15 - n : n;
    end
    return r;
  endfunction

  // Reference tick phase and LFSR; m_prev is the LFSR value seen by the last edge.
  int unsigned ph;
  logic        m_tick;
  logic [31:0] m_lfsr, m_prev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph     <= 0;
      m_tick <= 1'b0;
      m_lfsr <= '0;
      m_prev <= '0;
    end else begin
      m_tick <= (ph == TD - 1);
      ph     <= (ph == TD - 1) ? 0 : ph + 1;
      m_prev <= m_lfsr;
      if (bus.reseed) m_lfsr <= (bus.seed == 0) ? 32'd1 : bus.seed;
      else if (ph == TD - 1) m_lfsr <= (m_lfsr == 0) ? ((bus.seed == 0) ? 32'd1 : bus.seed) : ref_step(m_lfsr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain_lfsr(input int unsigned budget);
    for (int c = 0; c < budget && lfsr_q.size() != 0; c++) begin
      cyc();
      if (m_tick) begin
        chk("lfsr_seq", dut.u_lfsr.state, lfsr_q.pop_front());
        chk("idle_digits", bus.digits, IDLE_DIG);
      end
    end
    chk("lfsr_seq_complete", lfsr_q.size(), 0);
    lfsr_q.delete();
  endtask

  task automatic run_roll(input logic [31:0] tgt, input bit poke, input bit rsd, input logic [31:0] nseed);
    int unsigned n, t, L;
    logic [31:0] exp_dig, rnd, fin;
    bit seen;
    exp_dig    = cur_dig;
    bus.target = tgt;
    bus.start  = 1'b1;
    if (rsd) begin
      bus.seed   = nseed;
      bus.reseed = 1'b1;
    end
    cyc();
    bus.start  = 1'b0;
    bus.reseed = 1'b0;
    chk("busy_rise", bus.busy, 1);
    sb_q.push_back(DONE_T);
    n    = 0;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      if (poke && c == 6) begin
        bus.target = 32'h1111_1111;
        bus.start  = 1'b1;
      end
      if (poke && c == 7) bus.start = 1'b0;
      cyc();
      if (m_tick) begin
        n++;
        rnd = map_all(m_prev);
        t   = (n > RT) ? n - RT : 0;
        L   = (t == 0) ? 0 : (DP ? 6 : 7) - (t - 1) / ST;
        for (int i = 0; i < 8; i++) begin
          if (DP && i == 7)                                     exp_dig[4*i +: 4] = 4'hE;
          else if (t == 0)                                      exp_dig[4*i +: 4] = rnd[4*i +: 4];
          else if (i > int'(L) || (i == int'(L) && t % ST == 0)) exp_dig[4*i +: 4] = tgt[4*i +: 4];
          else                                                  exp_dig[4*i +: 4] = rnd[4*i +: 4];
        end
      end
      chk("digits", bus.digits, exp_dig);
      chk("busy", bus.busy, (n < DONE_T) ? 32'd1 : 32'd0);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        chk("done_tick", n, sb_q.pop_front());
      end
    end
    chk("done_seen", seen, 1);
    sb_q.delete();
    fin = DP ? {4'hE, tgt[27:0]} : tgt;
    cyc();
    chk("done_pulse_end", bus.done, 0);
    chk("busy_end", bus.busy, 0);
    chk("final_digits", bus.digits, fin);
    cur_dig = fin;
  endtask

  initial begin
    bus.seed   = 32'h1;
    bus.reseed = 1'b0;
    bus.start  = 1'b0;
    bus.target = '0;
    cur_dig    = IDLE_DIG;

    repeat (3) cyc();
    chk("rst_digits", bus.digits, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_lfsr", dut.u_lfsr.state, 0);

    rst = 1'b0;
    for (int k = 0; k <= 8; k++) lfsr_q.push_back(32'h1 << k);
    drain_lfsr(60);

    bus.seed   = 32'h8000_0001;
    bus.reseed = 1'b1;
    cyc();
    bus.reseed = 1'b0;
    chk("reseed_load", dut.u_lfsr.state, 32'h8000_0001);
    lfsr_q.push_back(32'h0000_00AD);
    lfsr_q.push_back(32'h0000_015A);
    drain_lfsr(20);

    chk("map_C", nibble_to_digit(4'hC), 4'd3);
    chk("map_9", nibble_to_digit(4'h9), 4'd9);
    chk("map_A", nibble_to_digit(4'hA), 4'd5);
    chk("map_F", nibble_to_digit(4'hF), 4'd0);

    bus.seed = 32'h1;
    run_roll(32'hF123_4567, 1'b0, 1'b0, 32'h0);
    run_roll(32'h0987_6543, 1'b1, 1'b1, 32'h0);

    bus.target = 32'h2468_1357;
    bus.start  = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    chk("midrst_digits", bus.digits, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    repeat (3) begin
      cyc();
      chk("midrst_no_done", bus.done, 0);
    end
    rst = 1'b0;
    repeat (2) cyc();
    chk("post_rst_digits", bus.digits, IDLE_DIG);
    cur_dig = IDLE_DIG;

    bus.seed = 32'hC0DE_5EED;
    run_roll(32'h5A5A_0F39, 1'b0, 1'b1, 32'hC0DE_5EED);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
